// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the integer register file.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_2r1w_sb_onehot_dec.sv
// Parametrised one-hot decoder: y = en ? (1 << sel) : 0.
module onehot_dec #(
  parameter int AW = 5
) (
  input  logic [AW-1:0]      sel,
  input  logic               en,
  output logic [(1<<AW)-1:0] y
);
  localparam int N = 1 << AW;

  // Single strobe at the selected index, all-zero when disabled
  always_comb begin
    y = '0;
    if (en) y = {{(N-1){1'b0}}, 1'b1} << sel;
  end
endmodule

// File: rtl/regfile_2r1w_sb.sv
// Decode-stage register file: 2 read ports, 1 write port, optional zero
// register, write-to-read bypass, optional registered read, and a
// per-register pending-write scoreboard.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = AW_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter int READ_LAT = 0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [AW-1:0]        ra1,
  output logic [XLEN-1:0]      rd1,
  input  logic [AW-1:0]        ra2,
  output logic [XLEN-1:0]      rd2,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic                 busy1,
  output logic                 busy2,
  output logic [(1<<AW)-1:0]   busy_vec
);
  localparam int NREGS = 1 << AW;

  if (!(READ_LAT == 0 || READ_LAT == 1) || AW < 1) begin : g_param_err
    $error("regfile_2r1w_sb: READ_LAT must be 0 or 1 and AW >= 1");
  end

  logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic [NREGS-1:0]           sb_q, sb_d;
  logic [NREGS-1:0]           wr_stb, sb_stb;
  logic [XLEN-1:0]            rv1, rv2;

  onehot_dec #(.AW(AW)) u_wdec  (.sel(waddr),   .en(we),     .y(wr_stb));
  onehot_dec #(.AW(AW)) u_sbdec (.sel(sb_addr), .en(sb_set), .y(sb_stb));

  // Next register contents; the zero register never takes a write
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_stb[i] && !(ZERO_REG && i == 0)) mem_d[i] = wdata;
    end
  end

  // Scoreboard next state: clear on writeback, set wins over clear
  always_comb begin
    sb_d = (sb_q & ~wr_stb) | sb_stb;
    if (ZERO_REG) sb_d[0] = 1'b0;
  end

  // Register array and scoreboard state; reset drops any in-flight update
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      sb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      sb_q  <= sb_d;
    end
  end

  // Read values with bypass; zero register overrides bypass
  always_comb begin
    rv1 = mem_q[ra1];
    rv2 = mem_q[ra2];
    if (BYPASS && we && waddr == ra1) rv1 = wdata;
    if (BYPASS && we && waddr == ra2) rv2 = wdata;
    if (ZERO_REG && ra1 == '0) rv1 = '0;
    if (ZERO_REG && ra2 == '0) rv2 = '0;
  end

  if (READ_LAT == 1) begin : g_rd_reg
    logic [XLEN-1:0] rd1_q, rd2_q;

    // Registered read, write-first via the bypassed value
    always_ff @(posedge clk) begin
      if (rst) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else begin
        rd1_q <= rv1;
        rd2_q <= rv2;
      end
    end

    assign rd1 = rd1_q;
    assign rd2 = rd2_q;
  end else begin : g_rd_comb
    assign rd1 = rv1;
    assign rd2 = rv2;
  end

  // Busy flags come from registered state only; a writeback this cycle
  // shows up next cycle
  assign busy_vec = sb_q;
  assign busy1    = sb_q[ra1];
  assign busy2    = sb_q[ra2];
endmodule
